// File: rtl/mem_wb_pkg.sv
// Shared opcode constants, opcode-class decode and stage-entry types for the
// MEM->WB pipeline register.
package mem_wb_pkg;

  // Opcodes are decoded at this width, so any OP_W up to 8 bits works.
  localparam int OP_MAX_W = 8;

  localparam logic [2:0] OP_LDR = 3'b001;
  localparam logic [2:0] OP_MOV = 3'b010;
  localparam logic [2:0] OP_LDI = 3'b110;
  localparam logic [2:0] OP_STR = 3'b011;

  typedef enum logic [1:0] {
    CLS_REG   = 2'd0,
    CLS_STORE = 2'd1,
    CLS_ACC   = 2'd2
  } op_class_e;

  // Write-enable half of a stage entry; these are the fields a bubble clears.
  typedef struct packed {
    logic reg_write;
    logic mem_write;
  } stage_ctrl_t;

  function automatic op_class_e op_class(input logic [OP_MAX_W-1:0] op);
    op_class_e cls;
    if (op == OP_MAX_W'(OP_LDR) || op == OP_MAX_W'(OP_MOV) || op == OP_MAX_W'(OP_LDI)) begin
      cls = CLS_REG;
    end else if (op == OP_MAX_W'(OP_STR)) begin
      cls = CLS_STORE;
    end else begin
      cls = CLS_ACC;
    end
    return cls;
  endfunction

endpackage

// File: rtl/mem_wb_merge.sv
// Merges an incoming entry's data fields with the current output register
// according to the opcode class; shared by the direct and skid load paths.
module mem_wb_merge
  import mem_wb_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [1:0]        cls_i,
  input  logic [DATA_W-1:0] new_acc_i,
  input  logic [DATA_W-1:0] new_mem_i,
  input  logic [DATA_W-1:0] new_reg_i,
  input  logic [DATA_W-1:0] cur_acc_i,
  input  logic [DATA_W-1:0] cur_mem_i,
  input  logic [DATA_W-1:0] cur_reg_i,
  output logic [DATA_W-1:0] acc_o,
  output logic [DATA_W-1:0] mem_o,
  output logic [DATA_W-1:0] reg_o
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned; a missing default here would infer a latch.
    acc_o = cur_acc_i;
    mem_o = cur_mem_i;
    reg_o = cur_reg_i;
    case (cls_i)
      CLS_REG:   reg_o = new_reg_i;
      CLS_STORE: mem_o = new_mem_i;
      default: begin
        acc_o = new_acc_i;
        mem_o = new_mem_i;
      end
    endcase
  end

endmodule

// File: rtl/mem_wb_pipe_reg.sv
// MEM->WB pipeline register with valid/ready handshake, flush, bubbles and
// class-selective data update. Define MEM_WB_SKID_EN for a one-entry skid buffer.
module mem_wb_pipe_reg
  import mem_wb_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int IMM_W  = 8,
  parameter int DEST_W = 5,
  parameter int OP_W   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_reg_write,
  input  logic              in_mem_write,
  input  logic [DEST_W-1:0] in_dest,
  input  logic [IMM_W-1:0]  in_imm,
  input  logic [DATA_W-1:0] in_acc_data,
  input  logic [DATA_W-1:0] in_mem_data,
  input  logic [DATA_W-1:0] in_reg_data,
  input  logic [OP_W-1:0]   in_opcode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_reg_write,
  output logic              out_mem_write,
  output logic [DEST_W-1:0] out_dest,
  output logic [IMM_W-1:0]  out_imm,
  output logic [DATA_W-1:0] out_acc_data,
  output logic [DATA_W-1:0] out_mem_data,
  output logic [DATA_W-1:0] out_reg_data,
  output logic [OP_W-1:0]   out_opcode
);

  logic              valid_q, valid_d;
  stage_ctrl_t       ctrl_q, ctrl_d;
  logic [DEST_W-1:0] dest_q, dest_d;
  logic [IMM_W-1:0]  imm_q, imm_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] mem_q, mem_d;
  logic [DATA_W-1:0] reg_q, reg_d;

  logic        accept, consume, load_out;
  op_class_e   in_cls;
  stage_ctrl_t in_ctrl;

  // Entry selected for loading into the output stage (input or skid).
  stage_ctrl_t       src_ctrl;
  logic [DEST_W-1:0] src_dest;
  logic [IMM_W-1:0]  src_imm;
  logic [OP_W-1:0]   src_op;
  logic [DATA_W-1:0] src_acc, src_mem, src_reg;
  op_class_e         src_cls;
  logic [DATA_W-1:0] mrg_acc, mrg_mem, mrg_reg;

  assign accept  = in_valid & in_ready;
  assign consume = valid_q & out_ready;
  assign in_cls  = op_class(OP_MAX_W'(in_opcode));
  assign in_ctrl = '{reg_write: in_reg_write, mem_write: in_mem_write};

`ifdef MEM_WB_SKID_EN
  logic              skid_valid_q, skid_valid_d, skid_load;
  stage_ctrl_t       skid_ctrl_q;
  logic [DEST_W-1:0] skid_dest_q;
  logic [IMM_W-1:0]  skid_imm_q;
  logic [OP_W-1:0]   skid_op_q;
  logic [DATA_W-1:0] skid_acc_q, skid_mem_q, skid_reg_q;
  op_class_e         skid_cls_q;

  // Ready depends only on state, so WB back-pressure never reaches MEM combinationally.
  assign in_ready  = rst & ~skid_valid_q;
  assign load_out  = (~valid_q | consume) & (skid_valid_q | accept);
  assign skid_load = accept & ~(load_out & ~skid_valid_q);

  always_comb begin
    src_ctrl = in_ctrl;
    src_dest = in_dest;
    src_imm  = in_imm;
    src_op   = in_opcode;
    src_acc  = in_acc_data;
    src_mem  = in_mem_data;
    src_reg  = in_reg_data;
    src_cls  = in_cls;
    if (skid_valid_q) begin
      src_ctrl = skid_ctrl_q;
      src_dest = skid_dest_q;
      src_imm  = skid_imm_q;
      src_op   = skid_op_q;
      src_acc  = skid_acc_q;
      src_mem  = skid_mem_q;
      src_reg  = skid_reg_q;
      src_cls  = skid_cls_q;
    end
  end

  always_comb begin
    skid_valid_d = skid_valid_q;
    if (flush) begin
      skid_valid_d = 1'b0;
    end else if (skid_load) begin
      skid_valid_d = 1'b1;
    end else if (load_out && skid_valid_q) begin
      skid_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      skid_valid_q <= 1'b0;
    end else begin
      skid_valid_q <= skid_valid_d;
    end
  end

  // NOTE: the skid payload has no reset; it is only ever read while
  // skid_valid_q is set, and that flag is reset.
  always_ff @(posedge clk) begin
    if (skid_load) begin
      skid_ctrl_q <= in_ctrl;
      skid_dest_q <= in_dest;
      skid_imm_q  <= in_imm;
      skid_op_q   <= in_opcode;
      skid_acc_q  <= in_acc_data;
      skid_mem_q  <= in_mem_data;
      skid_reg_q  <= in_reg_data;
      skid_cls_q  <= in_cls;
    end
  end
`else
  assign in_ready = rst & (~valid_q | out_ready);
  assign load_out = accept;

  always_comb begin
    src_ctrl = in_ctrl;
    src_dest = in_dest;
    src_imm  = in_imm;
    src_op   = in_opcode;
    src_acc  = in_acc_data;
    src_mem  = in_mem_data;
    src_reg  = in_reg_data;
    src_cls  = in_cls;
  end
`endif

  mem_wb_merge #(.DATA_W(DATA_W)) u_merge (
    .cls_i     (src_cls),
    .new_acc_i (src_acc),
    .new_mem_i (src_mem),
    .new_reg_i (src_reg),
    .cur_acc_i (acc_q),
    .cur_mem_i (mem_q),
    .cur_reg_i (reg_q),
    .acc_o     (mrg_acc),
    .mem_o     (mrg_mem),
    .reg_o     (mrg_reg)
  );

  // Flush beats load beats bubble; data fields always hold unless loaded.
  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    dest_d  = dest_q;
    imm_d   = imm_q;
    op_d    = op_q;
    acc_d   = acc_q;
    mem_d   = mem_q;
    reg_d   = reg_q;
    if (flush) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (load_out) begin
      valid_d = 1'b1;
      ctrl_d  = src_ctrl;
      dest_d  = src_dest;
      imm_d   = src_imm;
      op_d    = src_op;
      acc_d   = mrg_acc;
      mem_d   = mrg_mem;
      reg_d   = mrg_reg;
    end else if (consume) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      dest_q  <= '0;
      imm_q   <= '0;
      op_q    <= '0;
      acc_q   <= '0;
      mem_q   <= '0;
      reg_q   <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      dest_q  <= dest_d;
      imm_q   <= imm_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      mem_q   <= mem_d;
      reg_q   <= reg_d;
    end
  end

  assign out_valid     = valid_q;
  assign out_reg_write = ctrl_q.reg_write;
  assign out_mem_write = ctrl_q.mem_write;
  assign out_dest      = dest_q;
  assign out_imm       = imm_q;
  assign out_opcode    = op_q;
  assign out_acc_data  = acc_q;
  assign out_mem_data  = mem_q;
  assign out_reg_data  = reg_q;

endmodule
